// File: rtl/cc_position_driver_pkg.sv
// ============================================================================
// cc_position_driver_pkg : shared encodings and constants for the position driver
// Rev 1.0
// ============================================================================
`default_nettype none

package cc_position_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CRASH = 2'd2
  } posdrv_state_t;

  localparam int unsigned SEL_UBICACION = 0;
  localparam int unsigned SEL_NADA      = 1;

  localparam int unsigned CRASH_TOGGLE_LIMIT = 5;
  localparam int unsigned CRASH_TOGGLE_WIDTH = 3;

  // Home column is the upper of the two middle columns.
  function automatic int unsigned home_index(input int unsigned width);
    return width / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cc_blink_prescaler.sv
// ============================================================================
// cc_blink_prescaler : free-running period counter with one-cycle terminal pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module cc_blink_prescaler #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int                   CNT_WIDTH = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_WIDTH-1:0] c_last    = CNT_WIDTH'(PERIOD - 1);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (r_count == c_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign tick = enable && !clear && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/cc_position_driver.sv
// ============================================================================
// cc_position_driver : player position register and IDLE/PLAY/CRASH sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module cc_position_driver
  import cc_position_driver_pkg::*;
#(
  parameter int POSDRV_DATAWIDTH    = 8,
  parameter int POSDRV_SELECTWIDTH  = 2,
  parameter int POSDRV_BLINK_PERIOD = 12500000
) (
  input  logic                          CC_POSITIONDRIVER_CLOCK_50,
  input  logic                          CC_POSITIONDRIVER_RESET_InHigh,
  input  logic                          CC_POSITIONDRIVER_start_In,
  input  logic                          CC_POSITIONDRIVER_left_In,
  input  logic                          CC_POSITIONDRIVER_right_In,
  input  logic                          CC_POSITIONDRIVER_crash_In,
  output logic [POSDRV_SELECTWIDTH-1:0] CC_POSITIONDRIVER_select_OutBUS,
  output logic [POSDRV_DATAWIDTH-1:0]   CC_POSITIONDRIVER_UBICACION_OutBUS,
  output logic [POSDRV_DATAWIDTH-1:0]   CC_POSITIONDRIVER_NADA_OutBUS,
  output logic [1:0]                    CC_POSITIONDRIVER_state_OutBUS
);

  localparam int DW = POSDRV_DATAWIDTH;
  localparam int SW = POSDRV_SELECTWIDTH;

  localparam logic [DW-1:0] c_home   = DW'(1) << home_index(DW);
  localparam logic [SW-1:0] c_sel_ub = SW'(SEL_UBICACION);
  localparam logic [SW-1:0] c_sel_na = SW'(SEL_NADA);
  localparam logic [CRASH_TOGGLE_WIDTH-1:0] c_toggle_limit =
    CRASH_TOGGLE_WIDTH'(CRASH_TOGGLE_LIMIT);

  logic                          clk;
  logic                          rst;
  posdrv_state_t                 r_state;
  logic [DW-1:0]                 r_pos;
  logic [SW-1:0]                 r_select;
  logic [CRASH_TOGGLE_WIDTH-1:0] r_toggles;
  logic                          w_crash_entry;
  logic                          w_blink_tick;
  logic                          w_move_left;
  logic                          w_move_right;

  assign clk = CC_POSITIONDRIVER_CLOCK_50;
  assign rst = CC_POSITIONDRIVER_RESET_InHigh;

  assign w_crash_entry = (r_state == ST_PLAY) && CC_POSITIONDRIVER_crash_In;
  assign w_move_left   = CC_POSITIONDRIVER_left_In && !CC_POSITIONDRIVER_right_In;
  assign w_move_right  = CC_POSITIONDRIVER_right_In && !CC_POSITIONDRIVER_left_In;

  cc_blink_prescaler #(
    .PERIOD (POSDRV_BLINK_PERIOD)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_crash_entry),
    .enable (r_state == ST_CRASH),
    .tick   (w_blink_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pos     <= c_home;
      r_select  <= c_sel_ub;
      r_toggles <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pos    <= c_home;
          r_select <= c_sel_ub;
          if (CC_POSITIONDRIVER_start_In) begin
            r_state <= ST_PLAY;
          end
        end

        ST_PLAY: begin
          // Crash wins over any same-cycle move so the collision column is kept.
          if (CC_POSITIONDRIVER_crash_In) begin
            r_state   <= ST_CRASH;
            r_select  <= c_sel_ub;
            r_toggles <= '0;
          end else if (w_move_left) begin
            if (!r_pos[DW-1]) begin
              r_pos <= r_pos << 1;
            end
          end else if (w_move_right) begin
            if (!r_pos[0]) begin
              r_pos <= r_pos >> 1;
            end
          end
        end

        ST_CRASH: begin
          if (w_blink_tick) begin
            if (r_toggles == c_toggle_limit) begin
              r_state  <= ST_IDLE;
              r_pos    <= c_home;
              r_select <= c_sel_ub;
            end else begin
              r_select  <= (r_select == c_sel_ub) ? c_sel_na : c_sel_ub;
              r_toggles <= r_toggles + 1'b1;
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_pos    <= c_home;
          r_select <= c_sel_ub;
        end
      endcase
    end
  end

  assign CC_POSITIONDRIVER_select_OutBUS     = r_select;
  assign CC_POSITIONDRIVER_UBICACION_OutBUS  = r_pos;
  assign CC_POSITIONDRIVER_NADA_OutBUS       = '0;
  assign CC_POSITIONDRIVER_state_OutBUS      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cc_position_driver.sv
// ============================================================================
// tb_cc_position_driver : randomized and directed checks against a column model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cc_position_driver;

  localparam int DW = 8;
  localparam int SW = 2;
  localparam int P  = 4;
  localparam int HOME_COL = DW / 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          left = 1'b0;
  logic          right = 1'b0;
  logic          crash = 1'b0;
  logic [SW-1:0] sel;
  logic [DW-1:0] ubic;
  logic [DW-1:0] nada;
  logic [1:0]    state;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: state as int, player as a column number, crash as elapsed cycles.
  int m_state = 0;
  int m_col = HOME_COL;
  int m_t = 0;

  cc_position_driver #(
    .POSDRV_DATAWIDTH    (DW),
    .POSDRV_SELECTWIDTH  (SW),
    .POSDRV_BLINK_PERIOD (P)
  ) dut (
    .CC_POSITIONDRIVER_CLOCK_50         (clk),
    .CC_POSITIONDRIVER_RESET_InHigh     (rst),
    .CC_POSITIONDRIVER_start_In         (start),
    .CC_POSITIONDRIVER_left_In          (left),
    .CC_POSITIONDRIVER_right_In         (right),
    .CC_POSITIONDRIVER_crash_In         (crash),
    .CC_POSITIONDRIVER_select_OutBUS    (sel),
    .CC_POSITIONDRIVER_UBICACION_OutBUS (ubic),
    .CC_POSITIONDRIVER_NADA_OutBUS      (nada),
    .CC_POSITIONDRIVER_state_OutBUS     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sel();
    return (m_state == 2) ? 32'((m_t / P) % 2) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_ubic();
    return 32'(1) << m_col;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_col   = HOME_COL;
    m_t     = 0;
  endtask

  task automatic model_clock(input bit s, input bit l, input bit r, input bit c);
    case (m_state)
      0: begin
        m_col = HOME_COL;
        if (s) m_state = 1;
      end
      1: begin
        if (c) begin
          m_state = 2;
          m_t = 0;
        end else if (l && !r) begin
          m_col = (m_col + 1 > DW - 1) ? DW - 1 : m_col + 1;
        end else if (r && !l) begin
          m_col = (m_col - 1 < 0) ? 0 : m_col - 1;
        end
      end
      default: begin
        m_t++;
        if (m_t == 6 * P) begin
          m_state = 0;
          m_col = HOME_COL;
        end
      end
    endcase
  endtask

  task automatic step(input bit s, input bit l, input bit r, input bit c);
    start = s; left = l; right = r; crash = c;
    @(posedge clk);
    model_clock(s, l, r, c);
    #1;
    start = 1'b0; left = 1'b0; right = 1'b0; crash = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must react before any edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_ubic"}, 32'(ubic), 32'h10);
    check({tag, "_sel"}, 32'(sel), 32'h0);
    check({tag, "_nada"}, 32'(nada), 32'h0);
    check({tag, "_state"}, 32'(state), 32'h0);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("cyc_state", 32'(state), 32'(m_state));
      check("cyc_ubic", 32'(ubic), exp_ubic());
      check("cyc_sel", 32'(sel), exp_sel());
      check("cyc_nada", 32'(nada), 32'h0);
    end
  end

  initial begin
    logic [7:0] left_exp [4];
    logic [7:0] right_exp [5];
    logic [5:0] blink_pat;
    left_exp  = '{8'h20, 8'h40, 8'h80, 8'h80};
    right_exp = '{8'h08, 8'h04, 8'h02, 8'h01, 8'h01};
    blink_pat = 6'b010101;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    chk_en = 1'b1;

    async_reset("reset");

    step(0, 1, 0, 0);
    check("idle_left_ubic", 32'(ubic), 32'h10);
    step(0, 0, 1, 0);
    check("idle_right_ubic", 32'(ubic), 32'h10);
    step(0, 0, 0, 1);
    check("idle_crash_state", 32'(state), 32'h0);
    step(1, 0, 0, 0);
    check("start_state", 32'(state), 32'h1);

    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      check("left_sat_ubic", 32'(ubic), 32'(left_exp[i]));
    end

    async_reset("reset2");
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      check("right_sat_ubic", 32'(ubic), 32'(right_exp[i]));
    end
    step(0, 1, 1, 0);
    check("conflict_ubic", 32'(ubic), 32'h01);

    async_reset("reset3");
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    check("crash_state", 32'(state), 32'h2);
    check("crash_ubic", 32'(ubic), 32'h10);
    check("crash_sel0", 32'(sel), 32'h0);
    for (int i = 1; i < 24; i++) begin
      step(i == 6, i == 9, i == 13, i == 17);
      check("blink_sel", 32'(sel), 32'(blink_pat[5 - i / 4]));
      check("blink_state", 32'(state), 32'h2);
    end
    step(0, 0, 0, 0);
    check("crash_end_state", 32'(state), 32'h0);
    check("crash_end_sel", 32'(sel), 32'h0);
    check("crash_end_ubic", 32'(ubic), 32'h10);

    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("midcrash_sel_before", 32'(sel), 32'h1);
    async_reset("midcrash");
    step(1, 0, 0, 0);
    check("restart_state", 32'(state), 32'h1);
    check("restart_ubic", 32'(ubic), 32'h10);

    for (int i = 0; i < 3000; i++) begin
      bit s, l, r, c;
      s = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 39) == 0);
      step(s, l, r, c);
      if (i == 1500) async_reset("rand_reset");
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
